// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: boot delay, branch redirect bubbles,
// load-use stalls and halt/resume with a deferred branch replay.
module fetch_sequencer #(
    parameter int unsigned BOOT_CYCLES  = 2,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_write,
    output logic             pc_src,
    output logic [31:0]      pc_branch,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             fetch_valid,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

    localparam logic [7:0] BOOT_LOAD  = 8'(BOOT_CYCLES - 1);
    localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_CYCLES - 1);
    localparam bit         NO_FLUSH   = (FLUSH_CYCLES == 0);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             pend_v_q, pend_v_d;
    logic [31:0]      pend_tgt_q, pend_tgt_d;
    logic             redirect;
    logic [31:0]      redir_tgt;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            cnt_q      <= BOOT_LOAD;
            pend_v_q   <= 1'b0;
            pend_tgt_q <= 32'h0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_v_q   <= pend_v_d;
            pend_tgt_q <= pend_tgt_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_v_d    = pend_v_q;
        pend_tgt_d  = pend_tgt_q;
        redirect    = 1'b0;
        redir_tgt   = branch_target;
        pc_write    = 1'b1;
        pc_src      = 1'b0;
        pc_branch   = 32'h0;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        fetch_valid = 1'b1;
        halted      = 1'b0;

        unique case (state_q)
            BOOT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if_id_flush = 1'b1;
                fetch_valid = 1'b0;
                if (cnt_q == 8'd0) state_d = RUN;
                else cnt_d = cnt_q - 8'd1;
            end
            RUN: begin
                if (branch_taken) begin
                    redirect    = 1'b1;
                    if_id_flush = 1'b1;
                    fetch_valid = 1'b0;
                end else if (halt_req) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    state_d     = HALT;
                end else if (hazard_stall) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                end
            end
            FLUSH: begin
                if_id_flush = 1'b1;
                fetch_valid = 1'b0;
                if (branch_taken) redirect = 1'b1;
                else if (hazard_stall) pc_write = 1'b0;
                else if (cnt_q == 8'd0) state_d = RUN;
                else cnt_d = cnt_q - 8'd1;
            end
            HALT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if_id_flush = 1'b1;
                fetch_valid = 1'b0;
                halted      = 1'b1;
                if (resume) begin
                    // A live branch beats the stored one
                    redirect  = branch_taken || pend_v_q;
                    redir_tgt = branch_taken ? branch_target : pend_tgt_q;
                    pend_v_d  = 1'b0;
                    state_d   = RUN;
                end else if (branch_taken) begin
                    pend_v_d   = 1'b1;
                    pend_tgt_d = branch_target;
                end
            end
        endcase

        if (redirect) begin
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            pc_branch = redir_tgt;
            state_d   = NO_FLUSH ? RUN : FLUSH;
            cnt_d     = FLUSH_LOAD;
        end
    end

    always_comb begin
        count_d = count_q;
        if (redirect && (count_q != '1)) count_d = count_q + CNT_W'(1);
    end

    assign redirect_count = count_q;

endmodule
